// File: rtl/ibex_noc_msg_tracer.sv
`default_nettype none
// ============================================================================
// ibex_noc_msg_tracer: timestamped multi-channel NoC event capture, merged
// round-robin into one circular trace FIFO.                       Rev 1.0
// ============================================================================
module ibex_noc_msg_tracer #(
    parameter int unsigned NumCh     = 2,
    parameter int unsigned Depth     = 16,
    parameter int unsigned TsWidth   = 32,
    parameter int unsigned DropWidth = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         trace_en_i,
    input  logic                                         clear_i,
    input  logic [NumCh-1:0]                             ev_valid_i,
    input  logic [NumCh*2-1:0]                           ev_len_i,
    input  logic [NumCh*16-1:0]                          ev_addr_i,
    input  logic [NumCh*16-1:0]                          ev_core_i,
    input  logic [NumCh*32-1:0]                          ev_data_i,
    output logic                                         out_valid_o,
    input  logic                                         out_ready_i,
    output logic [((NumCh > 1) ? $clog2(NumCh) : 1)-1:0] out_ch_o,
    output logic [TsWidth-1:0]                           out_ts_o,
    output logic [1:0]                                   out_len_o,
    output logic [15:0]                                  out_addr_o,
    output logic [15:0]                                  out_core_o,
    output logic [31:0]                                  out_data_o,
    output logic [$clog2(Depth):0]                       level_o,
    output logic [DropWidth-1:0]                         drop_cnt_o,
    output logic                                         overflow_o
);
    localparam int unsigned ChW   = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned HoldW = TsWidth + 66;
    localparam int unsigned EntW  = ChW + HoldW;

    logic [TsWidth-1:0]   ts_q;
    logic [NumCh-1:0]     hold_vld_q, hold_vld_d;
    logic [HoldW-1:0]     hold_q [NumCh];
    logic [ChW-1:0]       rr_q, gnt_idx;
    logic                 gnt_vld;
    int unsigned          arb_idx;
    logic [EntW-1:0]      mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        level_q, level_d;
    logic [DropWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic [DropWidth:0]   drop_sum;
    logic                 overflow_q;
    logic                 pop, can_push;
    logic [NumCh-1:0]     load, drop;

    assign out_valid_o = (level_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign can_push    = (level_q != (PtrW+1)'(Depth)) | pop;
    assign level_d     = level_q + (PtrW+1)'(gnt_vld) - (PtrW+1)'(pop);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_idx = 0;
        for (int unsigned k = 0; k < NumCh; k++) begin
            arb_idx = (32'(rr_q) + k) % NumCh;
            if (can_push && !gnt_vld && hold_vld_q[ChW'(arb_idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = ChW'(arb_idx);
            end
        end
    end

    // A hold register freed by this cycle's grant can take a new event without loss.
    always_comb begin
        load       = '0;
        drop       = '0;
        hold_vld_d = hold_vld_q;
        for (int unsigned c = 0; c < NumCh; c++) begin
            if (gnt_vld && (gnt_idx == ChW'(c))) hold_vld_d[c] = 1'b0;
            if (ev_valid_i[c] && trace_en_i) begin
                if (hold_vld_d[c]) begin
                    drop[c] = 1'b1;
                end else begin
                    load[c]       = 1'b1;
                    hold_vld_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned c = 0; c < NumCh; c++) begin
            drop_sum = drop_sum + (DropWidth+1)'(drop[c]);
            if (drop_sum[DropWidth]) drop_sum = {1'b0, {DropWidth{1'b1}}};
        end
        drop_cnt_d = drop_sum[DropWidth-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q       <= '0;
            hold_vld_q <= '0;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            ts_q       <= '0;
            hold_vld_q <= '0;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_q + TsWidth'(1);
            hold_vld_q <= hold_vld_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_q | (|drop);
            level_q    <= level_d;
            if (gnt_vld) begin
                rr_q     <= (gnt_idx == ChW'(NumCh-1)) ? '0 : gnt_idx + ChW'(1);
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Payload storage carries no reset; validity lives in hold_vld_q and level_q.
    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NumCh; c++) begin
            if (load[c] && !clear_i) begin
                hold_q[c] <= {ts_q, ev_len_i[2*c +: 2], ev_addr_i[16*c +: 16],
                              ev_core_i[16*c +: 16], ev_data_i[32*c +: 32]};
            end
        end
        if (gnt_vld && !clear_i) mem_q[wr_ptr_q] <= {gnt_idx, hold_q[gnt_idx]};
    end

    assign {out_ch_o, out_ts_o, out_len_o, out_addr_o, out_core_o, out_data_o} =
        out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_noc_msg_tracer.sv
`default_nettype none
// ============================================================================
// tb_ibex_noc_msg_tracer: directed self-checking bench for the NoC tracer.
// Rev 1.0
// ============================================================================
module tb_ibex_noc_msg_tracer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_en;
    logic        clear;
    logic [1:0]  ev_valid;
    logic [3:0]  ev_len;
    logic [31:0] ev_addr;
    logic [31:0] ev_core;
    logic [63:0] ev_data;
    logic        out_ready;

    logic        out_valid;
    logic [0:0]  out_ch;
    logic [31:0] out_ts;
    logic [1:0]  out_len;
    logic [15:0] out_addr;
    logic [15:0] out_core;
    logic [31:0] out_data;
    logic [4:0]  level;
    logic [15:0] drop_cnt;
    logic        overflow;

    logic        out_valid4;
    logic [0:0]  out_ch4;
    logic [3:0]  out_ts4;
    logic [1:0]  out_len4;
    logic [15:0] out_addr4;
    logic [15:0] out_core4;
    logic [31:0] out_data4;
    logic [4:0]  level4;
    logic [15:0] drop_cnt4;
    logic        overflow4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ibex_noc_msg_tracer dut (
        .clk_i(clk), .rst_ni(rst_n), .trace_en_i(trace_en), .clear_i(clear),
        .ev_valid_i(ev_valid), .ev_len_i(ev_len), .ev_addr_i(ev_addr),
        .ev_core_i(ev_core), .ev_data_i(ev_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
        .out_ts_o(out_ts), .out_len_o(out_len), .out_addr_o(out_addr),
        .out_core_o(out_core), .out_data_o(out_data), .level_o(level),
        .drop_cnt_o(drop_cnt), .overflow_o(overflow)
    );

    ibex_noc_msg_tracer #(.TsWidth(4)) u_dut_ts4 (
        .clk_i(clk), .rst_ni(rst_n), .trace_en_i(trace_en), .clear_i(clear),
        .ev_valid_i(ev_valid), .ev_len_i(ev_len), .ev_addr_i(ev_addr),
        .ev_core_i(ev_core), .ev_data_i(ev_data),
        .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_ch_o(out_ch4),
        .out_ts_o(out_ts4), .out_len_o(out_len4), .out_addr_o(out_addr4),
        .out_core_o(out_core4), .out_data_o(out_data4), .level_o(level4),
        .drop_cnt_o(drop_cnt4), .overflow_o(overflow4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_dut();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic set_ev(input int ch, input logic [1:0] len, input logic [15:0] addr,
                          input logic [15:0] core, input logic [31:0] data);
        ev_len[ch*2 +: 2]   = len;
        ev_addr[ch*16 +: 16] = addr;
        ev_core[ch*16 +: 16] = core;
        ev_data[ch*32 +: 32] = data;
    endtask

    initial begin
        rst_n     = 1'b0;
        trace_en  = 1'b1;
        clear     = 1'b0;
        ev_valid  = '0;
        ev_len    = '0;
        ev_addr   = '0;
        ev_core   = '0;
        ev_data   = '0;
        out_ready = 1'b0;

        tick();
        tick();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_ts", out_ts, 0);
        rst_n = 1'b1;
        tick();

        // Single event on ch0 at ts=5
        clear_dut();
        repeat (5) tick();
        set_ev(0, 2'd2, 16'h0010, 16'h0003, 32'hCAFE0001);
        ev_valid = 2'b01;
        tick();
        ev_valid = '0;
        check_eq("t1_valid_early", out_valid, 0);
        tick();
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_ch", out_ch, 0);
        check_eq("t1_ts", out_ts, 5);
        check_eq("t1_len", out_len, 2);
        check_eq("t1_addr", out_addr, 16'h0010);
        check_eq("t1_core", out_core, 16'h0003);
        check_eq("t1_data", out_data, 32'hCAFE0001);
        check_eq("t1_level", level, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t1_level_drained", level, 0);

        // Both channels in the same cycle at ts=7, reader always ready
        clear_dut();
        repeat (7) tick();
        set_ev(0, 2'd1, 16'h0100, 16'h0001, 32'h11111111);
        set_ev(1, 2'd3, 16'h0200, 16'h0002, 32'h22222222);
        ev_valid  = 2'b11;
        out_ready = 1'b1;
        tick();
        ev_valid = '0;
        check_eq("t2_valid_early", out_valid, 0);
        tick();
        check_eq("t2_first_ch", out_ch, 0);
        check_eq("t2_first_ts", out_ts, 7);
        check_eq("t2_first_data", out_data, 32'h11111111);
        tick();
        check_eq("t2_second_ch", out_ch, 1);
        check_eq("t2_second_ts", out_ts, 7);
        check_eq("t2_second_len", out_len, 3);
        check_eq("t2_second_data", out_data, 32'h22222222);
        check_eq("t2_second_level", level, 1);
        tick();
        check_eq("t2_empty", level, 0);
        out_ready = 1'b0;

        // 20 events on ch0 with reader stalled: 16 in FIFO, 1 held, 3 dropped
        clear_dut();
        for (int i = 0; i < 20; i++) begin
            set_ev(0, 2'd0, 16'(i), 16'h0000, 32'(i));
            ev_valid = 2'b01;
            tick();
        end
        ev_valid = '0;
        check_eq("t3_level", level, 16);
        check_eq("t3_drop", drop_cnt, 3);
        check_eq("t3_ovf", overflow, 1);
        check_eq("t3_head", out_data, 0);

        // Full FIFO, reader ready, event every cycle: level holds, no new drops
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ev(0, 2'd0, 16'h0000, 16'h0000, 32'(100 + i));
            ev_valid = 2'b01;
            tick();
            check_eq("t4_level", level, 16);
        end
        ev_valid  = '0;
        out_ready = 1'b0;
        check_eq("t4_drop", drop_cnt, 3);
        check_eq("t4_head", out_data, 4);

        // One more drop, then drain to level 9, then clear
        set_ev(0, 2'd0, 16'h0000, 16'h0000, 32'd200);
        ev_valid = 2'b01;
        tick();
        ev_valid = '0;
        check_eq("t5_drop4", drop_cnt, 4);
        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        check_eq("t5_level9", level, 9);
        check_eq("t5_head12", out_data, 12);
        check_eq("t5_ovf_pre", overflow, 1);
        clear = 1'b1;
        set_ev(1, 2'd1, 16'h0300, 16'h0000, 32'd300);
        ev_valid  = 2'b10;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        ev_valid  = '0;
        out_ready = 1'b0;
        check_eq("t5_clr_level", level, 0);
        check_eq("t5_clr_drop", drop_cnt, 0);
        check_eq("t5_clr_ovf", overflow, 0);
        check_eq("t5_clr_valid", out_valid, 0);
        set_ev(0, 2'd0, 16'h0000, 16'h0000, 32'd400);
        ev_valid = 2'b01;
        tick();
        ev_valid = '0;
        tick();
        check_eq("t5_post_level", level, 1);
        check_eq("t5_post_ts", out_ts, 0);
        check_eq("t5_post_data", out_data, 400);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Timestamp wrap on the 4-bit instance: ts 15 then 0
        clear_dut();
        repeat (15) tick();
        set_ev(0, 2'd0, 16'h0000, 16'h0000, 32'h000000AA);
        ev_valid = 2'b01;
        tick();
        set_ev(0, 2'd0, 16'h0000, 16'h0000, 32'h000000BB);
        tick();
        ev_valid = '0;
        tick();
        check_eq("t6_level4", level4, 2);
        check_eq("t6_ts4_a", out_ts4, 15);
        check_eq("t6_data4_a", out_data4, 32'hAA);
        check_eq("t6_ts32_a", out_ts, 15);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t6_ts4_b", out_ts4, 0);
        check_eq("t6_data4_b", out_data4, 32'hBB);
        check_eq("t6_ts32_b", out_ts, 16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t6_empty", level, 0);

        // Capture disabled: nothing stored, nothing counted
        trace_en = 1'b0;
        ev_valid = 2'b11;
        repeat (3) tick();
        ev_valid = '0;
        tick();
        tick();
        check_eq("t7_level", level, 0);
        check_eq("t7_drop", drop_cnt, 0);
        check_eq("t7_valid", out_valid, 0);
        trace_en = 1'b1;

        // Asynchronous reset mid-operation
        set_ev(0, 2'd1, 16'h0ABC, 16'h0000, 32'd500);
        ev_valid = 2'b01;
        tick();
        tick();
        ev_valid = '0;
        check_eq("t8_level_pre", level, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t8_async_level", level, 0);
        check_eq("t8_async_valid", out_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("t8_no_residue", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
